alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
- Command sequencer and result register around the combinational 4-bit ALU.
- Accepts accumulator-style commands through a valid/ready port and buffers them in a small FIFO.
- Drives the ALU's A, B and ALU_Sel inputs: A is the internal accumulator, B and ALU_Sel come from the command.
- Captures ALU_Out and Carry_Out back into the accumulator and flags, and presents each result on a valid/ready output port.

Parameters:
- FIFO_DEPTH, 4, number of buffered commands; power of two, minimum 2.
- DATA_W, 4, datapath width; fixed to match the ALU, other values unsupported.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_load  input  1  1 = load cmd_data into the accumulator; 0 = ALU operation
- cmd_op  input  3  ALU_Sel encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shl, 111 shr
- cmd_data  input  DATA_W  B operand, or load value
- alu_a  output  DATA_W  to ALU A (the accumulator)
- alu_b  output  DATA_W  to ALU B
- alu_sel  output  3  to ALU_Sel
- alu_out  input  DATA_W  from ALU_Out
- alu_carry  input  1  from Carry_Out
- res_valid  output  1  result available
- res_ready  input  1  result consumed when res_valid && res_ready
- res_data  output  DATA_W  result (the new accumulator value)
- res_carry  output  1  carry/borrow flag
- res_zero  output  1  1 when res_data == 0
- acc  output  DATA_W  current accumulator, for debug

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FIFO emptied; state IDLE.
  - acc, alu_b, res_data = 0; alu_sel = 000.
  - res_valid, res_carry, res_zero = 0.
  - Any in-flight command is discarded.
- FIFO:
  - cmd_ready = (count != FIFO_DEPTH); push on handshake.
  - Pointers wrap modulo FIFO_DEPTH.
  - No bypass: an entry pushed in cycle N is poppable from cycle N+1.
  - Push and pop in the same cycle leave count unchanged.
- alu_a = acc. alu_b and alu_sel are registered copies of the popped command; they stay stable until the next pop.
- State machine:
  - IDLE: if FIFO is non-empty, pop into b_reg/op_reg/load_reg, go to EXEC; else stay in IDLE.
  - EXEC (one cycle, ALU inputs already stable):
    - load: acc <= b_reg; carry unchanged.
    - op 000/001: acc <= alu_out; carry <= alu_carry. For sub, carry = borrow, i.e. bit 4 of the 5-bit A-B (1 when A < B).
    - op 010-111: acc <= alu_out; carry held. Carry_Out is not driven by the ALU for these ops and must be ignored.
    - res_data <= new acc; res_zero <= (new acc == 0); res_valid <= 1; go to HOLD.
  - HOLD: outputs frozen. On res_ready: res_valid <= 0, go to IDLE. With res_ready low, HOLD is held indefinitely; the FIFO keeps accepting commands until full.
- Latency and throughput:
  - Command accepted into an empty FIFO in cycle 0 → popped in cycle 1 → EXEC in cycle 2 → res_valid high from cycle 3.
  - With res_ready tied high, peak throughput is one result per 3 cycles.
- Arithmetic is modulo 2^DATA_W; shifts fill with 0.

Optional Feature:
- Macro: ALU_CMD_OVF_EN.
- Defined:
  - Adds output port res_ovf (1 bit), reset 0, registered in EXEC.
  - add: res_ovf = (acc[3]==b[3]) && (alu_out[3]!=acc[3]).
  - sub: res_ovf = (acc[3]!=b[3]) && (alu_out[3]!=acc[3]).
  - All other ops and load: res_ovf = 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Load 9, then add 8, res_ready=1 → results 9 (carry 0, zero 0), then 1 (carry 1, zero 0); res_valid 3 cycles after the add is accepted into an empty FIFO.
- Load 3, sub 5 → res_data E, res_carry 1; then and F → res_data E, res_carry stays 1; then xor E → res_data 0, res_zero 1, carry stays 1.
- res_ready=0, offer 6 back-to-back commands → exactly 5 accepted (1 in HOLD + 4 buffered), cmd_ready low on the 6th. Release res_ready → results come out in order, and cmd_ready rises the cycle after the first pop.
- Load 8 then shl (110), then shr (111) → 0 with res_zero 1; then not (101) → F. Carry unchanged throughout.
- Assert rst while in HOLD with 3 commands queued → res_valid and acc go to 0 without waiting for clk; after release the FIFO is empty and cmd_ready = 1; the next add 2 gives 2.
- With ALU_CMD_OVF_EN: load 7, add 1 → res_data 8, res_ovf 1; load 8, sub 1 → 7, res_ovf 1; load 2, sub 1 → 1, res_ovf 0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Command sequencer and result register around a combinational
//            4-bit ALU. Commands arrive on a valid/ready port into a small
//            FIFO. Each popped command drives the ALU for one cycle against
//            the internal accumulator. The result is written back and then
//            offered on a valid/ready result port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FIFO_DEPTH : buffered commands (power of two, >= 2)
//   DATA_W     : datapath width (must be 4 to match the ALU)
// Ports
//   clk, rst              : clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_load/op/data      : load flag, ALU_Sel code, B operand or load value
//   alu_a/alu_b/alu_sel   : to the ALU (A is the accumulator)
//   alu_out/alu_carry     : from the ALU
//   res_valid/res_ready   : result handshake
//   res_data/carry/zero   : new accumulator, carry/borrow flag, zero flag
//   res_ovf               : signed overflow flag (only with ALU_CMD_OVF_EN)
//   acc                   : current accumulator, for debug
// Build option
//   ALU_CMD_OVF_EN        : when defined, adds the res_ovf output and logic
// ============================================================================
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic              res_zero,
`ifdef ALU_CMD_OVF_EN
    output logic              res_ovf,
`endif
    output logic [DATA_W-1:0] acc
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = DATA_W + 4;   // {load, op[2:0], data}
    localparam int c_MSB   = DATA_W - 1;

    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]         c_OP_ADD = 3'b000;
    localparam logic [2:0]         c_OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;

    logic [c_ENT_W-1:0]   r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic [DATA_W-1:0]    r_alu_b;
    logic [2:0]           r_alu_sel;
    logic                 r_load;
    logic [DATA_W-1:0]    r_acc;
    logic [DATA_W-1:0]    r_res_data;
    logic                 r_res_carry;
    logic                 r_res_zero;
    logic                 r_res_valid;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_exec;
    logic                 w_release;
    logic [c_ENT_W-1:0]   w_head;
    logic [DATA_W-1:0]    w_acc_nxt;
    logic                 w_carry_nxt;
    logic                 w_op_arith;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    assign cmd_ready = (r_count != c_FULL);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_head    = r_fifo_mem[r_rd_ptr];

    // Storage carries no reset: only entries below r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {cmd_load, cmd_op, cmd_data};
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two. The pop
    // decision looks only at the registered count, so a freshly pushed entry
    // becomes visible one cycle later (no bypass path).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_exec      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // ALU inputs were registered on the pop, so alu_out is
                // already settled for this cycle.
                w_exec      = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result computation
    // ------------------------------------------------------------------
    // Carry_Out is only meaningful for add and sub; for every other op the
    // ALU leaves it undriven, so the flag simply holds its previous value.
    assign w_op_arith  = !r_load && ((r_alu_sel == c_OP_ADD) || (r_alu_sel == c_OP_SUB));
    assign w_acc_nxt   = r_load ? r_alu_b : alu_out;
    assign w_carry_nxt = w_op_arith ? alu_carry : r_res_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_b     <= '0;
            r_alu_sel   <= 3'b000;
            r_load      <= 1'b0;
            r_acc       <= '0;
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
            r_res_zero  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_load    <= w_head[c_ENT_W-1];
                r_alu_sel <= w_head[DATA_W+2:DATA_W];
                r_alu_b   <= w_head[DATA_W-1:0];
            end
            if (w_exec) begin
                r_acc       <= w_acc_nxt;
                r_res_data  <= w_acc_nxt;
                r_res_carry <= w_carry_nxt;
                r_res_zero  <= (w_acc_nxt == '0);
                r_res_valid <= 1'b1;
            end else if (w_release) begin
                r_res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_CMD_OVF_EN
    // Two's-complement overflow: operands of equal sign for add (opposite
    // sign for sub) producing a result whose sign differs from A.
    logic w_ovf_nxt;
    logic r_res_ovf;

    always_comb begin
        w_ovf_nxt = 1'b0;
        if (!r_load) begin
            if (r_alu_sel == c_OP_ADD) begin
                w_ovf_nxt = (r_acc[c_MSB] == r_alu_b[c_MSB]) && (alu_out[c_MSB] != r_acc[c_MSB]);
            end else if (r_alu_sel == c_OP_SUB) begin
                w_ovf_nxt = (r_acc[c_MSB] != r_alu_b[c_MSB]) && (alu_out[c_MSB] != r_acc[c_MSB]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_ovf <= 1'b0;
        end else if (w_exec) begin
            r_res_ovf <= w_ovf_nxt;
        end
    end

    assign res_ovf = r_res_ovf;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_a     = r_acc;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign acc       = r_acc;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_carry = r_res_carry;
    assign res_zero  = r_res_zero;

endmodule

`default_nettype wire
